// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin, packet-locked arbiter that shares one uart_fifo write port
//   among NUM_REQ byte-stream requesters. A requester keeps the grant until it
//   hands over the last byte of its packet, so packets never interleave in the
//   TX FIFO. Free space is judged from fifo_dcount plus the write that is
//   still pending in this block's own output register, so the FIFO is never
//   overrun.
//
//   Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a stall timer
//   that forcibly releases a grant after TIMEOUT LOCK cycles without a
//   transfer. Without the macro there is no timer and abort is tied to 0.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active-low
//   req_valid    in   [NUM_REQ]            per-requester byte valid
//   req_data     in   [NUM_REQ*DATA_WIDTH] requester i uses [i*DW +: DW]
//   req_last     in   [NUM_REQ]            byte is the last of its packet
//   req_ready    out  [NUM_REQ]            byte accepted when valid & ready
//   fifo_wr      out  registered FIFO write strobe
//   fifo_din     out  [DATA_WIDTH] registered FIFO write data
//   fifo_dcount  in   [$clog2(FIFO_SIZE)+1] FIFO occupancy
//   grant        out  [NUM_REQ] registered one-hot current owner
//   busy         out  arbiter is locked to an owner
//   abort        out  one-cycle pulse on a timeout release
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic [$clog2(FIFO_SIZE):0]    fifo_dcount,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          abort
);

  localparam int IW = $clog2(NUM_REQ);
  // One extra bit over dcount so dcount + pending write can never wrap.
  localparam int CW = $clog2(FIFO_SIZE) + 2;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_LOCK = 1'b1;

  logic          state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [CW-1:0] fill_sum;
  logic          space_ok;
  logic          xfer;
  logic          release_lock;
  logic          timeout_hit;

  // Occupancy seen by the FIFO after our pending write lands.
  assign fill_sum = CW'(fifo_dcount) + CW'(fifo_wr);
  assign space_ok = fill_sum < CW'(FIFO_SIZE);

  assign busy      = (state == STATE_LOCK);
  assign req_ready = (state == STATE_LOCK && space_ok) ? grant : '0;
  assign xfer      = (state == STATE_LOCK) && req_valid[owner] && space_ok;

  assign release_lock = (xfer && req_last[owner]) || timeout_hit;

  // Cyclic search for the first valid requester at or after rr_ptr.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    sum        = 0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IW'(sum);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Arbitration FSM: lock onto a requester, release after its last byte
  // (or a timeout) and move the round-robin pointer past the old owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STATE_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      grant  <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (pick_found) begin
            state <= STATE_LOCK;
            owner <= pick_idx;
            grant <= NUM_REQ'(1) << pick_idx;
          end
        end
        STATE_LOCK: begin
          if (release_lock) begin
            state  <= STATE_IDLE;
            grant  <= '0;
            rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
          end
        end
        default: begin
          state <= STATE_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Write register: one cycle of latency from handshake to FIFO strobe.
  // Cleared by reset so a pending write of a dropped packet never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
    end else begin
      fifo_wr <= xfer;
      if (xfer) begin
        fifo_din <= req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] timer;

  // A transfer in the same cycle takes precedence over the timeout.
  assign timeout_hit = (state == STATE_LOCK) && !xfer && (timer == TW'(TIMEOUT));

  // Stall timer: counts LOCK cycles without a transfer; held at 0 outside
  // LOCK so every new lock starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      abort <= 1'b0;
    end else begin
      abort <= timeout_hit;
      if (state != STATE_LOCK || xfer || timeout_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  // Without the stall timer a grant is only released by req_last.
  assign timeout_hit    = 1'b0;
  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule
